// File: rtl/wb_daq_pkg.sv
// wb_daq_pkg - shared constants for the DAQ sample FIFO and the Wishbone
// register block that reads its status.
//   DAQ_DW / DAQ_AW : default word width / address width (depth = 2**DAQ_AW)
//   ST_*            : bit positions of the packed status word
//   daq_status_t    : status word layout, bit 0 = empty ... bit 4 = irq
package wb_daq_pkg;

    localparam int DAQ_DW = 32;
    localparam int DAQ_AW = 4;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_UNDERFLOW = 3;
    localparam int ST_IRQ       = 4;
    localparam int ST_W         = 5;

    // Field order gives empty at bit 0 through irq at bit 4, matching ST_*.
    typedef struct packed {
        logic irq;
        logic underflow;
        logic overflow;
        logic full;
        logic empty;
    } daq_status_t;

    function automatic daq_status_t pack_status(input logic empty, input logic full,
                                                input logic ovf, input logic udf,
                                                input logic irq);
        daq_status_t s;
        s.empty     = empty;
        s.full      = full;
        s.overflow  = ovf;
        s.underflow = udf;
        s.irq       = irq;
        return s;
    endfunction

endpackage

// File: rtl/wb_daq_fifo_ram.sv
// wb_daq_fifo_ram - simple dual-port RAM, 2**aw x dw, no reset.
//   wb_clk        : clock
//   we/waddr/wdata: write port, written on the rising edge when we=1
//   re/raddr      : read request; rdata is registered and updates only when re=1
//   rdata         : registered read data (returns old contents on a same-address
//                   read/write in one cycle)
module wb_daq_fifo_ram
    import wb_daq_pkg::*;
#(
    parameter int dw = DAQ_DW,
    parameter int aw = DAQ_AW
) (
    input  logic          wb_clk,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  logic [dw-1:0] wdata,
    input  logic          re,
    input  logic [aw-1:0] raddr,
    output logic [dw-1:0] rdata
);

    logic [dw-1:0] mem [2**aw];

    always_ff @(posedge wb_clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/wb_daq_fifo.sv
// wb_daq_fifo - synchronous sample FIFO between the DAQ aggregator and the
// Wishbone register/DMA side.
//   wb_clk, wb_rst_n          : clock, async active-low reset
//   fifo_push, data_in        : write strobe / data from the aggregator
//   fifo_pop                  : read strobe from the WB side
//   data_out, data_valid      : registered read data, one-cycle valid pulse
//   flush                     : synchronous empty, overrides push/pop
//   clear_flags               : clears sticky overflow/underflow
//   fifo_empty/full/count     : registered occupancy status
//   overflow, underflow       : sticky error flags
//   threshold                 : irq level (used only with the macro below)
//   fifo_threshold_irq        : level interrupt
// Build option: define WB_DAQ_FIFO_THRESHOLD_EN to build the threshold
// comparator; otherwise fifo_threshold_irq is tied to 0.
module wb_daq_fifo
    import wb_daq_pkg::*;
#(
    parameter int dw = DAQ_DW,
    parameter int aw = DAQ_AW
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic          fifo_push,
    input  logic [dw-1:0] data_in,
    input  logic          fifo_pop,
    output logic [dw-1:0] data_out,
    output logic          data_valid,
    input  logic          flush,
    input  logic          clear_flags,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic [aw:0]   fifo_count,
    output logic          overflow,
    output logic          underflow,
    input  logic [aw:0]   threshold,
    output logic          fifo_threshold_irq
);

    localparam logic [aw:0] FULL_CNT = (aw+1)'(2**aw);
    localparam logic [aw:0] ONE_CNT  = (aw+1)'(1);

    logic [aw-1:0] wr_ptr, rd_ptr;
    logic [aw:0]   count_nxt;
    logic          push_ok, pop_ok, ovf_evt, udf_evt;
    logic          have_data;
    logic [dw-1:0] ram_q;

    // A pop is only refused when empty; a push into a full FIFO still
    // succeeds when a pop frees a slot in the same cycle.
    always_comb begin
        pop_ok    = fifo_pop  & ~fifo_empty & ~flush;
        push_ok   = fifo_push & ~flush & (~fifo_full | pop_ok);
        ovf_evt   = fifo_push & fifo_full & ~fifo_pop & ~flush;
        udf_evt   = fifo_pop  & fifo_empty & ~flush;
        count_nxt = fifo_count;
        if (flush)
            count_nxt = '0;
        else if (push_ok && !pop_ok)
            count_nxt = fifo_count + ONE_CNT;
        else if (pop_ok && !push_ok)
            count_nxt = fifo_count - ONE_CNT;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            data_valid <= 1'b0;
            have_data  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= count_nxt;
            fifo_empty <= (count_nxt == '0);
            fifo_full  <= (count_nxt == FULL_CNT);
            data_valid <= pop_ok;
            if (pop_ok) have_data <= 1'b1;
            // A same-cycle error beats clear_flags.
            overflow   <= (overflow  & ~clear_flags) | ovf_evt;
            underflow  <= (underflow & ~clear_flags) | udf_evt;
        end
    end

    wb_daq_fifo_ram #(.dw(dw), .aw(aw)) u_ram (
        .wb_clk (wb_clk),
        .we     (push_ok),
        .waddr  (wr_ptr),
        .wdata  (data_in),
        .re     (pop_ok),
        .raddr  (rd_ptr),
        .rdata  (ram_q)
    );

    // The RAM read register has no reset; mask it until the first real pop
    // so data_out reads 0 out of reset. It holds across empty pops and flush.
    assign data_out = have_data ? ram_q : '0;

`ifdef WB_DAQ_FIFO_THRESHOLD_EN
    // Compares the registered count, so irq trails a count change by a cycle.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n)
            fifo_threshold_irq <= 1'b0;
        else
            fifo_threshold_irq <= (fifo_count >= threshold) && (threshold != '0);
    end
`else
    logic unused_threshold;
    assign unused_threshold   = ^threshold;
    assign fifo_threshold_irq = 1'b0;
`endif

endmodule

// File: tb/tb_wb_daq_fifo.sv
module tb_wb_daq_fifo;

    localparam int DEPTH = 16;
`ifdef WB_DAQ_FIFO_THRESHOLD_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        fifo_push = 1'b0, fifo_pop = 1'b0, flush = 1'b0, clear_flags = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        data_valid, fifo_empty, fifo_full, overflow, underflow, fifo_threshold_irq;
    logic [4:0]  fifo_count;
    logic [4:0]  thr = '0;

    wb_daq_fifo #(.dw(32), .aw(4)) dut (
        .wb_clk             (wb_clk),
        .wb_rst_n           (wb_rst_n),
        .fifo_push          (fifo_push),
        .data_in            (data_in),
        .fifo_pop           (fifo_pop),
        .data_out           (data_out),
        .data_valid         (data_valid),
        .flush              (flush),
        .clear_flags        (clear_flags),
        .fifo_empty         (fifo_empty),
        .fifo_full          (fifo_full),
        .fifo_count         (fifo_count),
        .overflow           (overflow),
        .underflow          (underflow),
        .threshold          (thr),
        .fifo_threshold_irq (fifo_threshold_irq)
    );

    always #5 wb_clk = ~wb_clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: a queue holds FIFO contents; sb holds words expected
    // on data_out, pushed when the pop is driven, popped when data_valid is seen.
    logic [31:0] mq[$];
    logic [31:0] sb[$];
    bit          m_ovf = 0, m_udf = 0, m_irq = 0, m_dv = 0;
    logic [31:0] m_dout = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit push, input logic [31:0] din, input bit pop,
                        input bit fl, input bit clr);
        int sz;
        bit pop_ok, push_ok, ovf_n, udf_n;
        @(negedge wb_clk);
        fifo_push = push; data_in = din; fifo_pop = pop; flush = fl; clear_flags = clr;
        sz = mq.size();
        if (fl) begin
            pop_ok = 0; push_ok = 0; ovf_n = 0; udf_n = 0;
        end else begin
            pop_ok  = pop && sz > 0;
            push_ok = push && (sz < DEPTH || pop_ok);
            ovf_n   = push && sz == DEPTH && !pop;
            udf_n   = pop && sz == 0;
        end
        m_irq = THR_EN && thr != 0 && sz >= int'(thr);
        if (fl) mq.delete();
        m_dv = pop_ok;
        if (pop_ok) begin
            m_dout = mq.pop_front();
            sb.push_back(m_dout);
        end
        if (push_ok) mq.push_back(din);
        m_ovf = (m_ovf && !clr) || ovf_n;
        m_udf = (m_udf && !clr) || udf_n;
        @(posedge wb_clk);
        #1;
        chk("count",     32'(fifo_count), 32'(mq.size()));
        chk("empty",     32'(fifo_empty), 32'(mq.size() == 0));
        chk("full",      32'(fifo_full),  32'(mq.size() == DEPTH));
        chk("overflow",  32'(overflow),   32'(m_ovf));
        chk("underflow", 32'(underflow),  32'(m_udf));
        chk("valid",     32'(data_valid), 32'(m_dv));
        chk("dout",      data_out,        m_dout);
        chk("irq",       32'(fifo_threshold_irq), 32'(m_irq));
        if (data_valid) begin
            if (sb.size() == 0) chk("sb_underrun", 32'(1), 32'(0));
            else                chk("sb_data", data_out, sb.pop_front());
        end
    endtask

    typedef struct {
        bit          push;
        logic [31:0] din;
        bit          pop;
        int          exp_count;
        bit          exp_dv;
        logic [31:0] exp_dout;
        bit          exp_empty;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{1, 32'h11111111, 0, 1, 0, 32'h0,        0};
        vt[1] = '{1, 32'h22222222, 0, 2, 0, 32'h0,        0};
        vt[2] = '{1, 32'h33333333, 0, 3, 0, 32'h0,        0};
        vt[3] = '{0, 32'h0,        1, 2, 1, 32'h11111111, 0};
        vt[4] = '{0, 32'h0,        1, 1, 1, 32'h22222222, 0};
        vt[5] = '{0, 32'h0,        1, 0, 1, 32'h33333333, 1};

        // Reset state
        #12;
        chk("rst_count", 32'(fifo_count), 32'(0));
        chk("rst_empty", 32'(fifo_empty), 32'(1));
        chk("rst_full",  32'(fifo_full),  32'(0));
        chk("rst_dout",  data_out,        32'(0));
        chk("rst_valid", 32'(data_valid), 32'(0));
        chk("rst_ovf",   32'(overflow),   32'(0));
        chk("rst_udf",   32'(underflow),  32'(0));
        chk("rst_irq",   32'(fifo_threshold_irq), 32'(0));
        @(negedge wb_clk);
        wb_rst_n = 1'b1;

        // Table: three pushes then three pops
        for (int i = 0; i < 6; i++) begin
            step(vt[i].push, vt[i].din, vt[i].pop, 0, 0);
            chk("tbl_count", 32'(fifo_count), 32'(vt[i].exp_count));
            chk("tbl_valid", 32'(data_valid), 32'(vt[i].exp_dv));
            chk("tbl_dout",  data_out,        vt[i].exp_dout);
            chk("tbl_empty", 32'(fifo_empty), 32'(vt[i].exp_empty));
        end

        // Fill past full: 17 pushes 0..16
        for (int i = 0; i < 17; i++) begin
            step(1, 32'(i), 0, 0, 0);
            if (i == 15) chk("full_at_16", 32'(fifo_full), 32'(1));
        end
        chk("ovf_17th", 32'(overflow), 32'(1));
        chk("cnt_17th", 32'(fifo_count), 32'(16));
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0, 0);
            chk("drain_val", data_out, 32'(i));
        end
        step(0, 0, 0, 0, 1);
        chk("ovf_clr", 32'(overflow), 32'(0));

        // Pop on empty, then clear
        step(0, 0, 1, 0, 0);
        chk("udf_set",   32'(underflow),  32'(1));
        chk("udf_valid", 32'(data_valid), 32'(0));
        chk("udf_hold",  data_out,        32'(15));
        step(0, 0, 0, 0, 1);
        chk("udf_clr", 32'(underflow), 32'(0));

        // Full, then simultaneous push and pop
        for (int i = 0; i < 16; i++) step(1, 32'h100 + 32'(i), 0, 0, 0);
        step(1, 32'h1ff, 1, 0, 0);
        chk("pp_full_cnt",  32'(fifo_count), 32'(16));
        chk("pp_full_ovf",  32'(overflow),   32'(0));
        chk("pp_full_dout", data_out,        32'h100);
        step(0, 0, 0, 1, 0);

        // Five pushes, then flush with a push
        for (int i = 0; i < 5; i++) step(1, 32'h200 + 32'(i), 0, 0, 0);
        step(1, 32'h2ff, 1, 1, 0);
        chk("fl_cnt",   32'(fifo_count), 32'(0));
        chk("fl_empty", 32'(fifo_empty), 32'(1));
        chk("fl_ovf",   32'(overflow),   32'(0));
        chk("fl_udf",   32'(underflow),  32'(0));
        chk("fl_valid", 32'(data_valid), 32'(0));
        step(1, 32'h300, 0, 0, 0);
        for (int i = 1; i <= 40; i++) begin
            step(1, 32'h300 + 32'(i), 1, 0, 0);
            chk("wrap_dout", data_out, 32'h300 + 32'(i - 1));
        end
        step(0, 0, 1, 0, 0);
        chk("wrap_last", data_out, 32'h328);
        chk("wrap_empty", 32'(fifo_empty), 32'(1));

        // Threshold interrupt
        thr = 5'd8;
        for (int i = 0; i < 8; i++) step(1, 32'h400 + 32'(i), 0, 0, 0);
        chk("irq_edge8", 32'(fifo_threshold_irq), 32'(0));
        step(0, 0, 0, 0, 0);
        chk("irq_hi", 32'(fifo_threshold_irq), 32'(THR_EN ? 1 : 0));
        step(0, 0, 1, 0, 0);
        chk("irq_pop7", 32'(fifo_threshold_irq), 32'(THR_EN ? 1 : 0));
        step(0, 0, 0, 0, 0);
        chk("irq_lo", 32'(fifo_threshold_irq), 32'(0));
        thr = 5'd0;
        for (int i = 0; i < 9; i++) step(1, 32'h500 + 32'(i), 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("irq_thr0", 32'(fifo_threshold_irq), 32'(0));
        step(0, 0, 0, 1, 0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 31) == 0) thr = 5'($urandom_range(0, 16));
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0);
        end

        chk("sb_drained", 32'(sb.size()), 32'(0));
        @(negedge wb_clk);
        fifo_push = 0; fifo_pop = 0; flush = 0; clear_flags = 0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
